sdram_port_arbiter: RTL

//  Slot-based arbiter sharing the single SDRAM controller port between the ROM/PRG

---
 rtl/sdram_port_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: one SDRAM access per clkref slot, shared by downloader, eraser and CPU.
module sdram_port_arbiter #(
   parameter int AW           = 25,
   parameter int DATA_LAT     = 6,
   parameter int STARVE_LIMIT = 0
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          clkref,
   input  logic          dl_req,
   input  logic [AW-1:0] dl_addr,
   input  logic [7:0]    dl_din,
   input  logic          dl_we,
   input  logic          er_req,
   input  logic [AW-1:0] er_addr,
   input  logic [7:0]    er_din,
   input  logic          er_we,
   input  logic          cpu_req,
   input  logic [AW-1:0] cpu_addr,
   input  logic [7:0]    cpu_din,
   input  logic          cpu_we,
   output logic          dl_ack,
   output logic          er_ack,
   output logic          cpu_ack,
   output logic [7:0]    rdata,
   output logic [1:0]    grant,
   output logic [AW-1:0] sdram_addr,
   output logic [7:0]    sdram_din,
   output logic          sdram_we,
   output logic          sdram_oe,
   input  logic [7:0]    sdram_dout
);
   localparam int SW = $clog2(STARVE_LIMIT + 2);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t          state_q, state_d;
   logic            clkref_q, slot_start, force_cpu, win_we;
   logic [2:0]      cnt_q, cnt_d, ack_q, ack_d;
   logic [1:0]      grant_q, grant_d, win;
   logic [AW-1:0]   addr_q, addr_d;
   logic [7:0]      din_q, din_d, rdata_q, rdata_d;
   logic            we_q, we_d, oe_q, oe_d;
   logic [SW-1:0]   starve_q, starve_d;
   assign slot_start = clkref & ~clkref_q;
   // a starved CPU overrides the fixed dl > er > cpu order
   assign force_cpu  = (STARVE_LIMIT > 0) && (starve_q == SW'(STARVE_LIMIT)) && cpu_req;
   assign win        = force_cpu ? 2'd3 : dl_req ? 2'd1 : er_req ? 2'd2 : cpu_req ? 2'd3 : 2'd0;
   assign win_we     = win == 2'd1 ? dl_we : win == 2'd2 ? er_we : cpu_we;
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      grant_d  = grant_q;
      addr_d   = addr_q;
      din_d    = din_q;
      we_d     = we_q;
      oe_d     = oe_q;
      rdata_d  = rdata_q;
      starve_d = starve_q;
      ack_d    = '0;
      if (state_q == IDLE) begin
         if (slot_start) begin
            starve_d = (win == 2'd3 || !cpu_req) ? '0 :
                       (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + SW'(1);
            if (win != 2'd0) begin
               state_d = BUSY;
               cnt_d   = '0;
               grant_d = win;
               addr_d  = win == 2'd1 ? dl_addr : win == 2'd2 ? er_addr : cpu_addr;
               din_d   = win == 2'd1 ? dl_din : win == 2'd2 ? er_din : cpu_din;
               we_d    = win_we;
               oe_d    = ~win_we;
            end
         end
      end else begin
         cnt_d = cnt_q + 3'd1;
         if (cnt_q == 3'(DATA_LAT - 1)) begin
            state_d = IDLE;
            cnt_d   = '0;
            grant_d = 2'd0;
            we_d    = 1'b0;
            oe_d    = 1'b0;
            rdata_d = oe_q ? sdram_dout : rdata_q;
            ack_d   = {grant_q == 2'd3, grant_q == 2'd2, grant_q == 2'd1};
         end
      end
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         clkref_q <= 1'b0;
         cnt_q    <= '0;
         grant_q  <= '0;
         addr_q   <= '0;
         din_q    <= '0;
         we_q     <= 1'b0;
         oe_q     <= 1'b0;
         rdata_q  <= '0;
         starve_q <= '0;
         ack_q    <= '0;
      end else begin
         state_q  <= state_d;
         clkref_q <= clkref;
         cnt_q    <= cnt_d;
         grant_q  <= grant_d;
         addr_q   <= addr_d;
         din_q    <= din_d;
         we_q     <= we_d;
         oe_q     <= oe_d;
         rdata_q  <= rdata_d;
         starve_q <= starve_d;
         ack_q    <= ack_d;
      end
   end
   assign {cpu_ack, er_ack, dl_ack} = ack_q;
   assign grant      = grant_q;
   assign rdata      = rdata_q;
   assign sdram_addr = addr_q;
   assign sdram_din  = din_q;
   assign sdram_we   = we_q;
   assign sdram_oe   = oe_q;
endmodule
